// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, request/ack memory port, one-entry skid, branch flush.
// Optional FETCH_PERF_EN adds FetchCount/StallCount counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemRData,
   output logic [31:0] InstrOut,
   output logic [31:0] PCOut,
   output logic [31:0] PCPlus8,
`ifdef FETCH_PERF_EN
   output logic [31:0] FetchCount,
   output logic [31:0] StallCount,
`endif
   output logic        InstrValid
);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT_SLOT} state_t;

   state_t      r_state, w_nxt_state;
   logic [31:0] r_pc, w_nxt_pc;
   logic [31:0] r_tgt, w_nxt_tgt;
   logic        r_flush, w_nxt_flush;
   logic [31:0] r_instr, w_nxt_instr;
   logic [31:0] r_pcout, w_nxt_pcout;
   logic        r_valid, w_nxt_valid;
   logic [31:0] r_skid_dat, w_nxt_skid_dat;
   logic [31:0] r_skid_addr, w_nxt_skid_addr;
   logic        w_slot_free;
   logic        w_accept;

   assign w_slot_free = !r_valid || !Stall;
   assign IMemReq     = (r_state == FETCH);
   assign IMemAddr    = (r_state == FETCH) ? r_pc : 32'h0;
   assign InstrOut    = r_instr;
   assign PCOut       = r_pcout;
   assign PCPlus8     = r_pcout + 32'd8;
   assign InstrValid  = r_valid;
   assign w_accept    = !BranchTaken && (r_state == FETCH) && IMemAck && !r_flush;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state     <= IDLE;
         r_pc        <= RESET_PC;
         r_tgt       <= 32'h0;
         r_flush     <= 1'b0;
         r_instr     <= 32'h0;
         r_pcout     <= 32'h0;
         r_valid     <= 1'b0;
         r_skid_dat  <= 32'h0;
         r_skid_addr <= 32'h0;
      end else begin
         r_state     <= w_nxt_state;
         r_pc        <= w_nxt_pc;
         r_tgt       <= w_nxt_tgt;
         r_flush     <= w_nxt_flush;
         r_instr     <= w_nxt_instr;
         r_pcout     <= w_nxt_pcout;
         r_valid     <= w_nxt_valid;
         r_skid_dat  <= w_nxt_skid_dat;
         r_skid_addr <= w_nxt_skid_addr;
      end
   end

   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_pc        = r_pc;
      w_nxt_tgt       = r_tgt;
      w_nxt_flush     = r_flush;
      w_nxt_instr     = r_instr;
      w_nxt_pcout     = r_pcout;
      w_nxt_valid     = r_valid;
      w_nxt_skid_dat  = r_skid_dat;
      w_nxt_skid_addr = r_skid_addr;
      if (BranchTaken) begin
         w_nxt_valid = 1'b0;
         // An un-acked request must still complete at its own address; park the target.
         if (r_state == FETCH && !IMemAck) begin
            w_nxt_flush = 1'b1;
            w_nxt_tgt   = BranchTarget;
         end else begin
            w_nxt_pc    = BranchTarget;
            w_nxt_flush = 1'b0;
            w_nxt_state = FETCH;
         end
      end else begin
         case (r_state)
            IDLE: w_nxt_state = FETCH;
            FETCH: begin
               if (IMemAck && r_flush) begin
                  w_nxt_pc    = r_tgt;
                  w_nxt_flush = 1'b0;
                  if (w_slot_free) w_nxt_valid = 1'b0;
               end else if (IMemAck) begin
                  w_nxt_pc = r_pc + PC_INC;
                  if (w_slot_free) begin
                     w_nxt_instr = IMemRData;
                     w_nxt_pcout = r_pc;
                     w_nxt_valid = 1'b1;
                  end else begin
                     w_nxt_skid_dat  = IMemRData;
                     w_nxt_skid_addr = r_pc;
                     w_nxt_state     = WAIT_SLOT;
                  end
               end else if (w_slot_free) begin
                  w_nxt_valid = 1'b0;
               end
            end
            WAIT_SLOT: begin
               if (!Stall) begin
                  w_nxt_instr = r_skid_dat;
                  w_nxt_pcout = r_skid_addr;
                  w_nxt_valid = 1'b1;
                  w_nxt_state = FETCH;
               end
            end
            default: w_nxt_state = IDLE;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_fetch_cnt <= 32'h0;
         r_stall_cnt <= 32'h0;
      end else begin
         if (w_accept && r_fetch_cnt != 32'hFFFF_FFFF) r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (r_valid && Stall && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign FetchCount = r_fetch_cnt;
   assign StallCount = r_stall_cnt;
`endif

endmodule
